slot_balance_pipe: RTL and testbench

- Parametrised in-order balancing pipe for the dual-issue core.
- Carries non-memory issue slots through DEPTH register ranks, so they reach writeback in the same cycle as the memory-slot partner.
- Supports LANES lanes, a global stall and a flush, and per-lane valid bits.
- Exposes every in-flight entry for forwarding, and keeps a retired-instruction counter.

---
 rtl/rv_pipe_pkg.sv | 24 ++
 rtl/slot_balance_pipe_slot_stage.sv | 74 +++++++
 rtl/slot_balance_pipe.sv | 112 +++++++++++
 tb/tb_slot_balance_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared constants, slot record and lane helpers for the balancing pipe.
package rv_pipe_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned RD_LSB    = 7;
  localparam int unsigned POP_W     = 32;

  typedef struct packed {
    logic                valid;
    logic                rf_we;
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] result;
  } slot_t;

  function automatic logic [5:0] popcount_lanes(input logic [POP_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < POP_W; i++) n += 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/slot_balance_pipe_slot_stage.sv
// One register rank holding LANES issue slots; flush beats stall.
module slot_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [LANES-1:0]      valid_i,
  input  logic [LANES-1:0]      rf_we_i,
  input  logic [LANES*XLEN-1:0] instr_i,
  input  logic [LANES*XLEN-1:0] pc_i,
  input  logic [LANES*XLEN-1:0] result_i,
  output logic [LANES-1:0]      valid_o,
  output logic [LANES-1:0]      rf_we_o,
  output logic [LANES*XLEN-1:0] instr_o,
  output logic [LANES*XLEN-1:0] pc_o,
  output logic [LANES*XLEN-1:0] result_o
);

  logic [LANES-1:0]      valid_q,  valid_d;
  logic [LANES-1:0]      rf_we_q,  rf_we_d;
  logic [LANES*XLEN-1:0] instr_q,  instr_d;
  logic [LANES*XLEN-1:0] pc_q,     pc_d;
  logic [LANES*XLEN-1:0] result_q, result_d;

  always_comb begin
    valid_d  = valid_q;
    rf_we_d  = rf_we_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    result_d = result_q;
    if (flush_i) begin
      valid_d  = '0;
      rf_we_d  = '0;
      instr_d  = '0;
      pc_d     = '0;
      result_d = '0;
    end else if (!stall_i) begin
      valid_d  = valid_i;
      // A bubble never carries a write enable down the pipe.
      rf_we_d  = valid_i & rf_we_i;
      instr_d  = instr_i;
      pc_d     = pc_i;
      result_d = result_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      rf_we_q  <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      result_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rf_we_q  <= rf_we_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      result_q <= result_d;
    end
  end

  assign valid_o  = valid_q;
  assign rf_we_o  = rf_we_q;
  assign instr_o  = instr_q;
  assign pc_o     = pc_q;
  assign result_o = result_q;

endmodule

// File: rtl/slot_balance_pipe.sv
// DEPTH-rank in-order balancing pipe with forwarding taps and retire counter.
module slot_balance_pipe
  import rv_pipe_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                stall_i,
  input  logic                                flush_i,
  input  logic [LANES-1:0]                    valid_i,
  input  logic [LANES*XLEN-1:0]               instr_i,
  input  logic [LANES*XLEN-1:0]               pc_i,
  input  logic [LANES*XLEN-1:0]               result_i,
  input  logic [LANES-1:0]                    rf_we_i,
  output logic [LANES-1:0]                    valid_o,
  output logic [LANES*XLEN-1:0]               instr_o,
  output logic [LANES*XLEN-1:0]               pc_o,
  output logic [LANES*XLEN-1:0]               result_o,
  output logic [LANES-1:0]                    rf_we_o,
  output logic [DEPTH*LANES-1:0]              fwd_we_o,
  output logic [DEPTH*LANES*REG_IDX_W-1:0]    fwd_rd_o,
  output logic [DEPTH*LANES*XLEN-1:0]         fwd_data_o,
  output logic [CNT_W-1:0]                    instret_o
);

  logic [LANES-1:0]      rk_valid  [DEPTH];
  logic [LANES-1:0]      rk_rf_we  [DEPTH];
  logic [LANES*XLEN-1:0] rk_instr  [DEPTH];
  logic [LANES*XLEN-1:0] rk_pc     [DEPTH];
  logic [LANES*XLEN-1:0] rk_result [DEPTH];

  logic [CNT_W-1:0] instret_q, instret_d;

  for (genvar s = 0; s < DEPTH; s++) begin : g_rank
    if (s == 0) begin : g_head
      slot_stage #(.LANES(LANES), .XLEN(XLEN)) u_stage (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .rf_we_i  (rf_we_i),
        .instr_i  (instr_i),
        .pc_i     (pc_i),
        .result_i (result_i),
        .valid_o  (rk_valid[s]),
        .rf_we_o  (rk_rf_we[s]),
        .instr_o  (rk_instr[s]),
        .pc_o     (rk_pc[s]),
        .result_o (rk_result[s])
      );
    end else begin : g_body
      slot_stage #(.LANES(LANES), .XLEN(XLEN)) u_stage (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .valid_i  (rk_valid[s-1]),
        .rf_we_i  (rk_rf_we[s-1]),
        .instr_i  (rk_instr[s-1]),
        .pc_i     (rk_pc[s-1]),
        .result_i (rk_result[s-1]),
        .valid_o  (rk_valid[s]),
        .rf_we_o  (rk_rf_we[s]),
        .instr_o  (rk_instr[s]),
        .pc_o     (rk_pc[s]),
        .result_o (rk_result[s])
      );
    end
  end

  assign valid_o  = rk_valid[DEPTH-1];
  assign rf_we_o  = rk_valid[DEPTH-1] & rk_rf_we[DEPTH-1];
  assign instr_o  = rk_instr[DEPTH-1];
  assign pc_o     = rk_pc[DEPTH-1];
  assign result_o = rk_result[DEPTH-1];

  // Entry s*LANES+l; writes to x0 are never offered for forwarding.
  always_comb begin
    logic [REG_IDX_W-1:0] rd;
    fwd_we_o   = '0;
    fwd_rd_o   = '0;
    fwd_data_o = '0;
    rd         = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        rd = rk_instr[s][l*XLEN+RD_LSB +: REG_IDX_W];
        fwd_we_o[s*LANES+l] = rk_valid[s][l] & rk_rf_we[s][l] & (rd != '0);
        fwd_rd_o[(s*LANES+l)*REG_IDX_W +: REG_IDX_W] = rd;
        fwd_data_o[(s*LANES+l)*XLEN +: XLEN] = rk_result[s][l*XLEN +: XLEN];
      end
    end
  end

  // A held output is counted only on the edge that lets it leave.
  always_comb begin
    instret_d = instret_q;
    if (!stall_i) instret_d = instret_q + CNT_W'(popcount_lanes(POP_W'(valid_o)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_slot_balance_pipe.sv
// Directed checks of the balancing pipe at DEPTH=3, LANES=2, CNT_W=4.
module tb_slot_balance_pipe;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic                         clk, rst, stall, flush;
  logic [LANES-1:0]             valid_i, rf_we_i, valid_o, rf_we_o;
  logic [LANES*XLEN-1:0]        instr_i, pc_i, result_i, instr_o, pc_o, result_o;
  logic [DEPTH*LANES-1:0]       fwd_we_o;
  logic [DEPTH*LANES*5-1:0]     fwd_rd_o;
  logic [DEPTH*LANES*XLEN-1:0]  fwd_data_o;
  logic [CNT_W-1:0]             instret_o;

  int n_checks = 0;
  int n_pass   = 0;

  slot_balance_pipe #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .stall_i    (stall),
    .flush_i    (flush),
    .valid_i    (valid_i),
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .result_i   (result_i),
    .rf_we_i    (rf_we_i),
    .valid_o    (valid_o),
    .instr_o    (instr_o),
    .pc_o       (pc_o),
    .result_o   (result_o),
    .rf_we_o    (rf_we_o),
    .fwd_we_o   (fwd_we_o),
    .fwd_rd_o   (fwd_rd_o),
    .fwd_data_o (fwd_data_o),
    .instret_o  (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd);
    return {20'h0, rd, 7'h13};
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [4:0] rd0,
                       input logic [4:0] rd1, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [31:0] r0, input logic [31:0] r1);
    valid_i  = v;
    rf_we_i  = we;
    instr_i  = {mk(rd1), mk(rd0)};
    pc_i     = {pc1, pc0};
    result_i = {r1, r0};
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic reset_dut();
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] rd_at(input int unsigned i);
    return fwd_rd_o[i*5 +: 5];
  endfunction

  initial begin
    // Reset behaviour with valid traffic presented throughout.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(2'b11, 2'b11, 5'd5, 5'd6, 32'h10, 32'h14, 32'h55, 32'h66);
    step(); step();
    check("rst_valid",   64'(valid_o),   64'(0));
    check("rst_rfwe",    64'(rf_we_o),   64'(0));
    check("rst_result",  64'(result_o),  64'(0));
    check("rst_fwdwe",   64'(fwd_we_o),  64'(0));
    check("rst_instret", 64'(instret_o), 64'(0));
    rst = 1'b0;
    check("rel_c0", 64'(valid_o), 64'(0));
    step(); check("rel_c1", 64'(valid_o), 64'(0));
    step(); check("rel_c2", 64'(valid_o), 64'(0));
    step();
    check("rel_c3_valid", 64'(valid_o), 64'(2'b11));
    check("rel_c3_res0",  64'(result_o[31:0]), 64'(32'h55));
    step();
    check("rel_instret", 64'(instret_o), 64'(2));
    rst = 1'b1; #1;
    check("midrst_valid",   64'(valid_o),   64'(0));
    check("midrst_instret", 64'(instret_o), 64'(0));
    check("midrst_fwdwe",   64'(fwd_we_o),  64'(0));
    step(); rst = 1'b0;

    // Latency of three cycles for a single lane-0 entry.
    reset_dut();
    drive(2'b01, 2'b01, 5'd5, 5'd0, 32'h100, 32'h0, 32'hAA, 32'h0);
    step(); idle();
    check("lat_fwdwe_r0", 64'(fwd_we_o), 64'(6'b000001));
    check("lat_fwdrd_r0", 64'(rd_at(0)), 64'(5));
    step(); step();
    check("lat_valid",   64'(valid_o),         64'(2'b01));
    check("lat_result",  64'(result_o[31:0]),  64'(32'hAA));
    check("lat_pc",      64'(pc_o[31:0]),      64'(32'h100));
    check("lat_rfwe",    64'(rf_we_o),         64'(2'b01));
    check("lat_instret0", 64'(instret_o),      64'(0));
    step();
    check("lat_instret1", 64'(instret_o), 64'(1));
    check("lat_drain",    64'(valid_o),   64'(0));

    // Stall with the entry in rank 1, then a stall holding the output.
    reset_dut();
    drive(2'b01, 2'b01, 5'd5, 5'd0, 32'h100, 32'h0, 32'hAA, 32'h0);
    step(); idle();
    step();
    stall = 1'b1;
    drive(2'b11, 2'b11, 5'd9, 5'd9, 32'h1, 32'h2, 32'h3, 32'h4);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_fwdrd2", 64'(rd_at(2)), 64'(5));
      check("stall_fwdwe",  64'(fwd_we_o), 64'(6'b000100));
    end
    check("stall_valid", 64'(valid_o), 64'(0));
    stall = 1'b0; idle();
    step();
    check("stall_out_valid", 64'(valid_o),   64'(2'b01));
    check("stall_out_fwdwe", 64'(fwd_we_o),  64'(6'b010000));
    check("stall_out_cnt",   64'(instret_o), 64'(0));
    stall = 1'b1;
    step(); step();
    check("hold_valid", 64'(valid_o),   64'(2'b01));
    check("hold_cnt",   64'(instret_o), 64'(0));
    stall = 1'b0;
    step();
    check("release_cnt",   64'(instret_o), 64'(1));
    check("release_valid", 64'(valid_o),   64'(0));
    step();
    check("release_once", 64'(instret_o), 64'(1));

    // Flush beats stall with six live entries.
    reset_dut();
    drive(2'b11, 2'b11, 5'd3, 5'd4, 32'h20, 32'h24, 32'h77, 32'h88);
    step(); step(); step();
    check("pre_flush_fwdwe", 64'(fwd_we_o), 64'(6'b111111));
    check("pre_flush_valid", 64'(valid_o),  64'(2'b11));
    stall = 1'b1; flush = 1'b1;
    step();
    check("flush_fwdwe",   64'(fwd_we_o),          64'(0));
    check("flush_valid",   64'(valid_o),           64'(0));
    check("flush_data",    64'(fwd_data_o[31:0]),  64'(0));
    check("flush_instret", 64'(instret_o),         64'(0));
    stall = 1'b0; flush = 1'b0; idle();
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_flush_valid", 64'(valid_o), 64'(0));
    end
    check("post_flush_cnt", 64'(instret_o), 64'(0));

    // Forwarding with x0 destination and a bubble carrying rf_we.
    reset_dut();
    drive(2'b11, 2'b11, 5'd7, 5'd0, 32'h30, 32'h34, 32'h11, 32'h22);
    step();
    drive(2'b10, 2'b11, 5'd9, 5'd3, 32'h38, 32'h3C, 32'h33, 32'h44);
    check("fwd_we_x0",  64'(fwd_we_o),          64'(6'b000001));
    check("fwd_rd_e0",  64'(rd_at(0)),          64'(7));
    check("fwd_rd_e1",  64'(rd_at(1)),          64'(0));
    check("fwd_data1",  64'(fwd_data_o[63:32]), 64'(32'h22));
    step(); idle();
    check("fwd_we_mix", 64'(fwd_we_o), 64'(6'b000110));
    step();
    check("fwd_out1_valid", 64'(valid_o), 64'(2'b11));
    check("fwd_out1_rfwe",  64'(rf_we_o), 64'(2'b11));
    step();
    check("bubble_valid", 64'(valid_o),          64'(2'b10));
    check("bubble_rfwe",  64'(rf_we_o),          64'(2'b10));
    check("bubble_res1",  64'(result_o[63:32]),  64'(32'h44));

    // Counter wrap at four bits.
    reset_dut();
    drive(2'b11, 2'b11, 5'd1, 5'd2, 32'h40, 32'h44, 32'h1, 32'h2);
    step(); step(); step();
    check("wrap_start", 64'(instret_o), 64'(0));
    for (int i = 1; i <= 8; i++) begin
      step();
      check("wrap_cnt", 64'(instret_o), 64'((2 * i) % 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
